// File: rtl/trs80_pkg.sv
// ----------------------------------------------------------------------------
// trs80_pkg : shared types and constants for the joystick SAR scanner
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package trs80_pkg;

  localparam int JOY_BITS     = 6;
  localparam int JOY_CHANNELS = 4;

  localparam logic [1:0] JOY0 = 2'b00;
  localparam logic [1:0] JOY1 = 2'b01;
  localparam logic [1:0] JOY2 = 2'b10;
  localparam logic [1:0] JOY3 = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TRIAL  = 3'd1,
    WAIT   = 3'd2,
    SAMPLE = 3'd3,
    NEXT   = 3'd4,
    DONE   = 3'd5
  } joy_sar_state_t;

  // Lowest-numbered channel present in a mask (JOY3 when the mask is empty).
  function automatic logic [1:0] lowest_chan(input logic [JOY_CHANNELS-1:0] m);
    if (m[0])      return JOY0;
    else if (m[1]) return JOY1;
    else if (m[2]) return JOY2;
    else           return JOY3;
  endfunction

endpackage

`default_nettype wire

// File: rtl/trs80_sar_step.sv
// ----------------------------------------------------------------------------
// trs80_sar_step : single-channel 6-bit successive-approximation engine
// Revision       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module trs80_sar_step
  import trs80_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                go,
  input  logic                hilo,
  output logic [JOY_BITS-1:0] dac,
  output logic [JOY_BITS-1:0] result,
  output logic                fin
);

  localparam int CW = (SETTLE > 2) ? $clog2(SETTLE) : 1;

  joy_sar_state_t      phase, phase_nx;
  logic [JOY_BITS-1:0] acc, acc_nx, dac_nx;
  logic [2:0]          bit_idx, bit_nx;
  logic [CW-1:0]       cnt, cnt_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase   <= IDLE;
      acc     <= '0;
      dac     <= '0;
      bit_idx <= '0;
      cnt     <= '0;
    end else begin
      phase   <= phase_nx;
      acc     <= acc_nx;
      dac     <= dac_nx;
      bit_idx <= bit_nx;
      cnt     <= cnt_nx;
    end
  end

  always_comb begin
    phase_nx = phase;
    acc_nx   = acc;
    dac_nx   = dac;
    bit_nx   = bit_idx;
    cnt_nx   = cnt;
    fin      = 1'b0;
    // The trial value already holds the bit under test, so a 1 keeps it.
    result   = hilo ? dac : acc;

    case (phase)
      IDLE: begin
        if (go) begin
          phase_nx = TRIAL;
          acc_nx   = '0;
          bit_nx   = 3'(JOY_BITS - 1);
        end
      end
      TRIAL: begin
        dac_nx   = acc | (JOY_BITS'(1) << bit_idx);
        cnt_nx   = CW'(SETTLE - 2);
        phase_nx = WAIT;
      end
      WAIT: begin
        if (cnt == '0) phase_nx = SAMPLE;
        else           cnt_nx   = cnt - CW'(1);
      end
      SAMPLE: begin
        acc_nx = result;
        if (bit_idx == 3'd0) begin
          fin = 1'b1;
          if (go) begin
            // Back-to-back channel: restart without an idle cycle.
            phase_nx = TRIAL;
            acc_nx   = '0;
            bit_nx   = 3'(JOY_BITS - 1);
          end else begin
            phase_nx = IDLE;
            dac_nx   = '0;
          end
        end else begin
          bit_nx   = bit_idx - 3'd1;
          phase_nx = TRIAL;
        end
      end
      default: phase_nx = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/trs80_joy_sar.sv
// ----------------------------------------------------------------------------
// trs80_joy_sar : four-channel SAR joystick scanner; JOYSCAN_AUTO_EN adds
//                 periodic rescans after the first external start.
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module trs80_joy_sar
  import trs80_pkg::*;
#(
  parameter int SETTLE = 2
`ifdef JOYSCAN_AUTO_EN
  , parameter logic [15:0] AUTO_INTERVAL = 16'd1000
`endif
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [JOY_CHANNELS-1:0] chan_mask,
  input  logic                    hilo,
  output logic [JOY_BITS-1:0]     dac,
  output logic                    selb,
  output logic                    sela,
  output logic                    busy,
  output logic                    done,
  output logic [JOY_BITS-1:0]     joy0,
  output logic [JOY_BITS-1:0]     joy1,
  output logic [JOY_BITS-1:0]     joy2,
  output logic [JOY_BITS-1:0]     joy3,
  output logic                    snd_mute
);

  joy_sar_state_t          state, state_nx;
  logic [JOY_CHANNELS-1:0] rem, scan_mask, pick_src;
  logic [1:0]              sel, pick;
  logic [JOY_BITS-1:0]     joy [JOY_CHANNELS];
  logic [JOY_BITS-1:0]     step_result;
  logic                    go, fin, trig;

`ifdef JOYSCAN_AUTO_EN
  logic                    armed, auto_fire;
  logic [15:0]             auto_cnt;
  logic [JOY_CHANNELS-1:0] last_mask;

  assign auto_fire = armed && (state == IDLE) && (auto_cnt == AUTO_INTERVAL - 16'd1);
  assign trig      = (state == IDLE) && (start || auto_fire);
  assign scan_mask = start ? chan_mask : last_mask;

  // Counter only advances in IDLE, so it measures idle time since the last done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed     <= 1'b0;
      auto_cnt  <= '0;
      last_mask <= '0;
    end else if ((state == IDLE) && start) begin
      armed     <= 1'b1;
      auto_cnt  <= '0;
      last_mask <= chan_mask;
    end else if ((state == IDLE) && armed) begin
      auto_cnt  <= auto_fire ? 16'd0 : auto_cnt + 16'd1;
    end else begin
      auto_cnt  <= '0;
    end
  end
`else
  assign trig      = (state == IDLE) && start;
  assign scan_mask = chan_mask;
`endif

  assign pick_src = (state == IDLE) ? scan_mask : rem;
  assign pick     = lowest_chan(pick_src);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // NEXT spans a whole channel conversion; the channel hand-off happens on fin.
  always_comb begin
    state_nx = state;
    go       = 1'b0;
    case (state)
      IDLE: begin
        if (trig) begin
          if (scan_mask != '0) begin
            state_nx = NEXT;
            go       = 1'b1;
          end else begin
            state_nx = DONE;
          end
        end
      end
      NEXT: begin
        if (fin) begin
          if (rem != '0) go       = 1'b1;
          else           state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem <= '0;
      sel <= JOY0;
      for (int i = 0; i < JOY_CHANNELS; i++) joy[i] <= '0;
    end else begin
      if ((state == NEXT) && fin) joy[sel] <= step_result;
      if (go) begin
        sel <= pick;
        rem <= pick_src & ~(JOY_CHANNELS'(1) << pick);
      end else if ((state == NEXT) && fin) begin
        sel <= JOY0;
      end
    end
  end

  trs80_sar_step #(
    .SETTLE (SETTLE)
  ) u_step (
    .clk     (clk),
    .reset_n (reset_n),
    .go      (go),
    .hilo    (hilo),
    .dac     (dac),
    .result  (step_result),
    .fin     (fin)
  );

  assign {selb, sela} = sel;
  assign busy         = (state == NEXT);
  assign done         = (state == DONE);
  assign snd_mute     = busy;
  assign joy0         = joy[0];
  assign joy1         = joy[1];
  assign joy2         = joy[2];
  assign joy3         = joy[3];

endmodule

`default_nettype wire

// File: tb/tb_trs80_joy_sar.sv
// ----------------------------------------------------------------------------
// tb_trs80_joy_sar : scoreboard bench for trs80_joy_sar with a registered
//                    comparator model and randomized joystick positions.
// ----------------------------------------------------------------------------
`default_nettype none

module tb_trs80_joy_sar;

  localparam int SETTLE = 2;
  localparam int CH_CYC = 6 * (SETTLE + 1);

  logic       clk = 1'b0;
  logic       reset_n, start, hilo = 1'b0;
  logic [3:0] chan_mask;
  logic [5:0] dac, joy0, joy1, joy2, joy3;
  logic       selb, sela, busy, done, snd_mute;

  trs80_joy_sar #(.SETTLE(SETTLE)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .chan_mask(chan_mask),
    .hilo(hilo), .dac(dac), .selb(selb), .sela(sela), .busy(busy),
    .done(done), .joy0(joy0), .joy1(joy1), .joy2(joy2), .joy3(joy3),
    .snd_mute(snd_mute)
  );

  always #5 clk = ~clk;

  logic [5:0] stick [4];
  always @(posedge clk) hilo <= (stick[{selb, sela}] >= dac);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [1:0] sel; logic [5:0] dac; } trial_t;
  typedef struct {
    int             start_cyc;
    int             lat;
    int             busy_cycles;
    logic [3:0][5:0] joy;
  } exp_t;

  trial_t      trial_q[$];
  exp_t        exp_q[$];
  logic [5:0]  mdl_joy [4];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Binary search with a >= comparator: every trial the scanner must present.
  task automatic push_trials(input logic [1:0] ch, input int v);
    int acc = 0;
    for (int k = 5; k >= 0; k--) begin
      int t = acc + (1 << k);
      trial_q.push_back('{sel: ch, dac: 6'(t)});
      if (v >= t) acc = t;
    end
  endtask

  task automatic issue(input logic [3:0] m, input bit accept);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    start = 1'b1;
    chan_mask = m;
    if (accept) begin
      for (int c = 0; c < 4; c++) begin
        if (m[c]) begin
          n++;
          mdl_joy[c] = stick[c];
          push_trials(2'(c), int'(stick[c]));
        end
      end
      e.start_cyc   = cyc;
      e.lat         = 1 + n * CH_CYC;
      e.busy_cycles = n * CH_CYC;
      for (int c = 0; c < 4; c++) e.joy[c] = mdl_joy[c];
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    chan_mask = 4'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    chk("scan_timeout", exp_q.size(), 0);
    repeat (4) @(negedge clk);
    chk("trials_left", trial_q.size(), 0);
  endtask

  // Monitor: pops expectations whenever the DUT shows a trial or a done pulse.
  initial begin
    logic [5:0] prev_dac = '0;
    int         busy_cnt = 0;
    trial_t     t;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_q.delete();
        trial_q.delete();
        busy_cnt = 0;
        prev_dac = '0;
      end else begin
        if (busy) busy_cnt++;
        if (dac != prev_dac && dac != 6'd0) begin
          if (trial_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_trial actual=%0d expected=none", dac);
          end else begin
            t = trial_q.pop_front();
            chk("trial_dac", dac, t.dac);
            chk("trial_sel", {selb, sela}, t.sel);
          end
        end
        prev_dac = dac;
        if (done) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_done actual=1 expected=0 cyc=%0d", cyc);
          end else begin
            e = exp_q.pop_front();
            chk("done_latency", cyc - e.start_cyc, e.lat);
            chk("busy_cycles", busy_cnt, e.busy_cycles);
            chk("busy_at_done", busy, 0);
            chk("dac_at_done", dac, 0);
            chk("sel_at_done", {selb, sela}, 0);
            chk("joy0", joy0, e.joy[0]);
            chk("joy1", joy1, e.joy[1]);
            chk("joy2", joy2, e.joy[2]);
            chk("joy3", joy3, e.joy[3]);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dac"}, dac, 0);
    chk({tag, "_sel"}, {selb, sela}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mute"}, snd_mute, 0);
    chk({tag, "_joys"}, {joy0, joy1, joy2, joy3}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] m;
    reset_n = 1'b0;
    start = 1'b0;
    chan_mask = 4'd0;
    for (int c = 0; c < 4; c++) begin stick[c] = '0; mdl_joy[c] = '0; end
    #12;
    chk_reset_outputs("reset");
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    stick[0] = 6'h2A;
    issue(4'b0001, 1); wait_done();

    stick[0] = 6'd0; stick[1] = 6'd63; stick[2] = 6'd1; stick[3] = 6'd62;
    issue(4'b1111, 1); wait_done();

    issue(4'b0000, 1); wait_done();

    stick[0] = 6'd5; stick[1] = 6'd7;
    issue(4'b0011, 1); wait_done();
    stick[0] = 6'd20; stick[1] = 6'd30; stick[2] = 6'd44; stick[3] = 6'd50;
    issue(4'b0100, 1); wait_done();

    issue(4'b1010, 1); repeat (10) @(negedge clk); issue(4'b0101, 0); wait_done();

    issue(4'b0001, 1); repeat (1 + CH_CYC - 2) @(negedge clk); issue(4'b1111, 0); wait_done();

    for (int it = 0; it < 24; it++) begin
      for (int c = 0; c < 4; c++) stick[c] = 6'($urandom_range(0, 63));
      m = 4'($urandom);
      n = $countones(m);
      issue(m, 1);
      if (n != 0 && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, n * CH_CYC - 2)) @(negedge clk);
        issue(4'($urandom), 0);
      end
      wait_done();
    end

    for (int c = 0; c < 4; c++) stick[c] = 6'($urandom_range(1, 63));
    issue(4'b1111, 1); wait_done();
    issue(4'b1111, 1);
    repeat (30) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    for (int c = 0; c < 4; c++) mdl_joy[c] = '0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("postreset");

    stick[3] = 6'd33;
    issue(4'b1000, 1); wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/trs80_joy_sar.md
Name: trs80_joy_sar

Overview:
- Hardware successive-approximation joystick scanner; the initiator side of the CoCo joystick comparator.
- Drives the 6-bit DAC value and the selb/sela mux select, then samples the comparator's registered hilo result (hilo=1 when joystick ≥ dac).
- Produces four 6-bit digitized joystick axes without CPU polling.
- Sits beside the DAC/comparator block; used for auto-read and for bench self-check of the comparator path.

Parameters:
- SETTLE, 2: cycles from a dac/sel change to hilo sampling; minimum 2 because the comparator output is registered.
- AUTO_INTERVAL, 16'd1000: idle cycles between automatic scans; used only when JOYSCAN_AUTO_EN is defined.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle scan request; sampled only in IDLE
- chan_mask  in  4  channels to convert; bit n = channel n; sampled with start
- hilo  in  1  comparator result from the DAC/comparator block
- dac  out  6  trial value to the DAC
- selb  out  1  mux select high bit
- sela  out  1  mux select low bit
- busy  out  1  high while a scan is in progress
- done  out  1  one-cycle pulse at scan completion
- joy0 / joy1 / joy2 / joy3  out  6 each  conversion results; channel n uses {selb,sela}=n
- snd_mute  out  1  equals busy; tells the sound path the sel lines are being borrowed

Behaviour:
- Reset: dac=0, selb=sela=0, busy=0, done=0, joy0..joy3=0, state IDLE. Reset mid-scan aborts at once; partial results are discarded and outputs return to reset values.
- States:
  - IDLE: wait for start.
  - TRIAL: register dac and sel.
  - WAIT: count SETTLE-1 cycles.
  - SAMPLE: read hilo, decide the bit.
  - NEXT: choose the next bit or channel.
  - DONE: pulse done.
- IDLE→TRIAL on start, with the lowest set bit of chan_mask selected. chan_mask is latched on start.
- Start with chan_mask=0: done pulses on the next cycle; busy stays 0; sel is not driven.
- Per channel:
  - acc starts at 0; bit k runs from 5 down to 0.
  - TRIAL drives dac = acc | (1<<k) and {selb,sela} = channel index.
  - After SETTLE cycles from the TRIAL edge, SAMPLE captures hilo. If hilo=1, acc keeps bit k; otherwise bit k is cleared.
  - Each bit takes exactly SETTLE+1 cycles. One channel takes 6*(SETTLE+1) cycles.
- Result equals the joystick's top 6 bits exactly, values 0..63 inclusive. 63 is reachable because the comparator uses ≥.
- joyN updates in the cycle after channel N's last SAMPLE. joyN for unmasked channels holds its previous value.
- Channels are converted in ascending index; masked-out channels cost 0 cycles.
- Scan end: dac returns to 0 and {selb,sela} to 00 (DAC sound path, silent level). done pulses one cycle; busy deasserts in the same cycle done asserts.
- Latency from start to done = 1 + Nmasked*6*(SETTLE+1) cycles.
- start while busy is ignored, not queued. start coincident with done is ignored.
- busy asserts the cycle after start is accepted.

Optional Feature:
- Macro JOYSCAN_AUTO_EN.
- Defined:
  - After each done, an interval counter runs for AUTO_INTERVAL cycles in IDLE, then starts a scan using the last latched chan_mask.
  - An external start during the interval takes effect immediately with the new mask and resets the counter.
  - No automatic scan occurs before the first external start after reset.
- Not defined: scans occur only on start; the interval counter logic is absent.

Decomposition:
- Shared package trs80_pkg holds:
  - state enum joy_sar_state_t (IDLE, TRIAL, WAIT, SAMPLE, NEXT, DONE);
  - constant JOY_BITS=6;
  - constant JOY_CHANNELS=4;
  - localparam SEL codes JOY0..JOY3 = 2'b00..2'b11.
- One natural sub-module, trs80_sar_step: a single-channel 6-bit SAR engine covering acc, bit index and settle counter. It has go/hilo inputs and dac/result/fin outputs. The top level sequences channels and owns sel, mask, the result registers and the auto counter.

Test Plan:
- Comparator model (registered, hilo = joy ≥ dac), SETTLE=2, joystick ch0=0x2A, start with mask=4'b0001:
  - joy0=0x2A;
  - done exactly 19 cycles after start;
  - dac trial sequence 32,48,40,44,42,43.
- Mask=4'b1111, channels 0..3 = 0, 63, 1, 62:
  - joy0..3 = 0, 63, 1, 62;
  - sel steps 00,01,10,11;
  - done at 1+4*18=73 cycles.
- Mask=4'b0000: done pulses next cycle, busy never asserts, joy outputs unchanged.
- Mask=4'b0100 from preset results joy0=5, joy1=7: only joy2 updates; joy0=5 and joy1=7 are held.
- start pulsed again mid-scan is ignored, and the scan completes once. reset_n low mid-scan clears all outputs to 0 asynchronously.
- With JOYSCAN_AUTO_EN and AUTO_INTERVAL=10: after the first start, rescans begin 10 idle cycles after each done. A joystick change between scans is reflected in the next results.
